// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive-side control path.
// No logic here; state encoding and default sizing only.
package uart_pkg;
    localparam int UART_DATA_W     = 8;
    localparam int UART_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rx_state_e;
endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO with registered pointers; read data is combinational from the head, one-cycle write-to-visible.
// Push while full succeeds only alongside a pop; pop while empty is ignored; rdata reads zero when empty.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 9,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    // Storage is not reset, so mask the head while empty to keep outputs defined.
    assign rdata_o = empty_o ? '0 : mem_q[rd_q];

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = wr_q + AW'(1);
        if (do_pop)  rd_d = rd_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end
endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: gates the core, applies error policy, buffers bytes, keeps error stats.
// frm_done to out_valid is one cycle; out_ready stalls the FIFO and frames arriving while full are lost (overrun).
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_FIFO_DEPTH,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rx_en,
    input  logic                     drop_bad,
    input  logic                     frm_done,
    input  logic [UART_DATA_W-1:0]   frm_data,
    input  logic                     frm_perr,
    input  logic                     frm_serr,
    output logic                     core_en,
    output logic                     out_valid,
    output logic [UART_DATA_W-1:0]   out_data,
    output logic                     out_err,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_cnt,
    output logic [CNT_W-1:0]         perr_cnt,
    output logic [CNT_W-1:0]         serr_cnt,
    output logic                     overrun,
    input  logic                     clr_stat
);
    rx_state_e          state_q, state_d;
    logic [CNT_W-1:0]   perr_q, perr_d, serr_q, serr_d;
    logic               ovr_q, ovr_d;
    logic               accept, bad, want_push, pop, lost, fifo_full, fifo_empty;

    assign accept    = frm_done && (state_q != IDLE);
    assign bad       = frm_perr || frm_serr;
    assign want_push = accept && !(bad && drop_bad);
    assign pop       = out_valid && out_ready;
    assign lost      = want_push && fifo_full && !pop;

    assign core_en   = (state_q != IDLE);
    assign out_valid = !fifo_empty;
    assign perr_cnt  = perr_q;
    assign serr_cnt  = serr_q;
    assign overrun   = ovr_q;

    uart_rx_fifo #(.DEPTH(DEPTH), .W(UART_DATA_W + 1)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (want_push),
        .pop_i   (pop),
        .wdata_i ({bad, frm_data}),
        .rdata_o ({out_err, out_data}),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rx_en) state_d = RUN;
            RUN:     if (!rx_en) state_d = DRAIN;
            // Hold the core on while a frame is still landing.
            DRAIN:   if (rx_en) state_d = RUN;
                     else if (!frm_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Events outrank clear, so a coincident error restarts the count at one.
    always_comb begin
        perr_d = perr_q;
        serr_d = serr_q;
        ovr_d  = ovr_q;
        if (clr_stat) begin
            perr_d = '0;
            serr_d = '0;
            ovr_d  = 1'b0;
        end
        if (accept && frm_perr) perr_d = clr_stat ? CNT_W'(1) : (&perr_q ? perr_q : perr_q + CNT_W'(1));
        if (accept && frm_serr) serr_d = clr_stat ? CNT_W'(1) : (&serr_q ? serr_q : serr_q + CNT_W'(1));
        if (lost) ovr_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            perr_q  <= '0;
            serr_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            perr_q  <= perr_d;
            serr_q  <= serr_d;
            ovr_q   <= ovr_d;
        end
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scenario bench for uart_rx_ctrl with a byte scoreboard queue.
module tb_uart_rx_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_en = 1'b0, drop_bad = 1'b0, frm_done = 1'b0;
    logic [7:0] frm_data = 8'h00;
    logic       frm_perr = 1'b0, frm_serr = 1'b0;
    logic       core_en, out_valid, out_err, overrun;
    logic [7:0] out_data, perr_cnt, serr_cnt;
    logic       out_ready = 1'b0, clr_stat = 1'b0;
    logic [2:0] fifo_cnt;

    int errors = 0;
    int checks = 0;
    logic [8:0] sb [$];

    uart_rx_ctrl #(.DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .rx_en(rx_en), .drop_bad(drop_bad),
        .frm_done(frm_done), .frm_data(frm_data), .frm_perr(frm_perr), .frm_serr(frm_serr),
        .core_en(core_en), .out_valid(out_valid), .out_data(out_data), .out_err(out_err),
        .out_ready(out_ready), .fifo_cnt(fifo_cnt), .perr_cnt(perr_cnt), .serr_cnt(serr_cnt),
        .overrun(overrun), .clr_stat(clr_stat)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one frame for one cycle; the expected byte enters the scoreboard when pushed.
    task automatic send(input logic [7:0] d, input logic p, input logic s, input logic exp_push);
        frm_done = 1'b1;
        frm_data = d;
        frm_perr = p;
        frm_serr = s;
        if (exp_push) sb.push_back({p | s, d});
        step();
        frm_done = 1'b0;
        frm_perr = 1'b0;
        frm_serr = 1'b0;
    endtask

    task automatic pop_check(input string name);
        logic [8:0] exp;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, out_valid=%0b", name, out_valid);
        end else begin
            exp = sb.pop_front();
            if (out_valid !== 1'b1 || {out_err, out_data} !== exp) begin
                errors++;
                $display("FAIL %s: got valid=%0b err=%0b data=%02h, want valid=1 err=%0b data=%02h",
                         name, out_valid, out_err, out_data, exp[8], exp[7:0]);
            end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        step(); step();
        checks++;
        if ({core_en, out_valid, out_err, out_data, fifo_cnt, perr_cnt, serr_cnt, overrun} !== '0) begin
            errors++;
            $display("FAIL reset_init: core_en=%0b valid=%0b err=%0b data=%02h cnt=%0d perr=%0d serr=%0d ovr=%0b, want all 0",
                     core_en, out_valid, out_err, out_data, fifo_cnt, perr_cnt, serr_cnt, overrun);
        end
        reset = 1'b1;
        rx_en = 1'b1;
        step();
        send(8'hE1, 1'b0, 1'b0, 1'b1);
        send(8'hE2, 1'b0, 1'b0, 1'b1);
        checks++;
        if (fifo_cnt !== 3'd2) begin
            errors++;
            $display("FAIL reset_prefill: fifo_cnt=%0d want 2", fifo_cnt);
        end
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if ({core_en, out_valid, out_err, out_data, fifo_cnt, overrun} !== '0) begin
            errors++;
            $display("FAIL reset_async: core_en=%0b valid=%0b err=%0b data=%02h cnt=%0d ovr=%0b, want all 0",
                     core_en, out_valid, out_err, out_data, fifo_cnt, overrun);
        end
        rx_en = 1'b0;
        sb.delete();
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_single();
        checks++;
        if (core_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_core_en: got %0b want 0", core_en);
        end
        rx_en = 1'b1;
        step();
        checks++;
        if (core_en !== 1'b1) begin
            errors++;
            $display("FAIL run_core_en: got %0b want 1", core_en);
        end
        send(8'hA5, 1'b0, 1'b0, 1'b1);
        checks++;
        if (fifo_cnt !== 3'd1) begin
            errors++;
            $display("FAIL single_cnt: got %0d want 1", fifo_cnt);
        end
        pop_check("single_pop");
        checks++;
        if (fifo_cnt !== 3'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_empty: cnt=%0d valid=%0b want 0/0", fifo_cnt, out_valid);
        end
    endtask

    task automatic test_err_policy();
        drop_bad = 1'b0;
        send(8'h3C, 1'b1, 1'b0, 1'b1);
        checks++;
        if (perr_cnt !== 8'd1) begin
            errors++;
            $display("FAIL perr_count: got %0d want 1", perr_cnt);
        end
        pop_check("perr_kept");
        drop_bad = 1'b1;
        send(8'h5A, 1'b0, 1'b1, 1'b0);
        checks++;
        if (serr_cnt !== 8'd1 || fifo_cnt !== 3'd0) begin
            errors++;
            $display("FAIL serr_drop: serr=%0d cnt=%0d want 1/0", serr_cnt, fifo_cnt);
        end
        drop_bad = 1'b0;
        send(8'h11, 1'b1, 1'b1, 1'b1);
        checks++;
        if (perr_cnt !== 8'd2 || serr_cnt !== 8'd2) begin
            errors++;
            $display("FAIL both_err: perr=%0d serr=%0d want 2/2", perr_cnt, serr_cnt);
        end
        pop_check("both_kept");
    endtask

    task automatic test_overrun();
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b0, 1'b0, 1'b1);
        send(8'h05, 1'b0, 1'b0, 1'b0);
        checks++;
        if (fifo_cnt !== 3'd4 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_full: cnt=%0d ovr=%0b want 4/1", fifo_cnt, overrun);
        end
        for (int i = 0; i < 4; i++) pop_check("overrun_pop");
        clr_stat = 1'b1;
        step();
        clr_stat = 1'b0;
        checks++;
        if (overrun !== 1'b0 || perr_cnt !== 8'd0 || serr_cnt !== 8'd0) begin
            errors++;
            $display("FAIL clr_stat: ovr=%0b perr=%0d serr=%0d want 0", overrun, perr_cnt, serr_cnt);
        end
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b0, 1'b0, 1'b1);
        checks++;
        if ({out_err, out_data} !== sb.pop_front()) begin
            errors++;
            $display("FAIL full_pushpop_head: got %02h want 01", out_data);
        end
        out_ready = 1'b1;
        send(8'h05, 1'b0, 1'b0, 1'b1);
        out_ready = 1'b0;
        checks++;
        if (fifo_cnt !== 3'd4 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL full_pushpop: cnt=%0d ovr=%0b want 4/0", fifo_cnt, overrun);
        end
        for (int i = 0; i < 4; i++) pop_check("full_pushpop_pop");
    endtask

    task automatic test_saturation();
        drop_bad = 1'b1;
        for (int i = 0; i < 260; i++) send(8'(i), 1'b1, 1'b0, 1'b0);
        checks++;
        if (perr_cnt !== 8'hFF || serr_cnt !== 8'h00 || fifo_cnt !== 3'd0) begin
            errors++;
            $display("FAIL perr_sat: perr=%02h serr=%02h cnt=%0d want FF/00/0", perr_cnt, serr_cnt, fifo_cnt);
        end
        clr_stat = 1'b1;
        send(8'h99, 1'b1, 1'b0, 1'b0);
        clr_stat = 1'b0;
        checks++;
        if (perr_cnt !== 8'd1) begin
            errors++;
            $display("FAIL clr_vs_perr: perr=%0d want 1", perr_cnt);
        end
        drop_bad = 1'b0;
    endtask

    task automatic test_disable();
        rx_en = 1'b0;
        send(8'h77, 1'b0, 1'b0, 1'b1);
        checks++;
        if (core_en !== 1'b1 || fifo_cnt !== 3'd1) begin
            errors++;
            $display("FAIL drain_state: core_en=%0b cnt=%0d want 1/1", core_en, fifo_cnt);
        end
        step();
        checks++;
        if (core_en !== 1'b0) begin
            errors++;
            $display("FAIL drain_to_idle: core_en=%0b want 0", core_en);
        end
        send(8'h88, 1'b1, 1'b0, 1'b0);
        checks++;
        if (fifo_cnt !== 3'd1 || perr_cnt !== 8'd1) begin
            errors++;
            $display("FAIL idle_ignore: cnt=%0d perr=%0d want 1/1", fifo_cnt, perr_cnt);
        end
        pop_check("drain_byte");
        checks++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL final_empty: sb=%0d valid=%0b want 0/0", sb.size(), out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_err_policy();
        test_overrun();
        test_saturation();
        test_disable();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
